// File: rtl/fir_pkg.sv
// Shared widths, sample/coefficient types and FSM states for the complex
// symmetric FIR engine.
package fir_pkg;
  localparam int SAMP_W = 24;
  localparam int COEF_W = 27;
  localparam int OUT_W  = 32;
  localparam int FOLD_W = SAMP_W + 1;
  // Two 52-bit products summed or differenced need one extra bit.
  localparam int PROD_W = FOLD_W + COEF_W + 1;

  typedef struct packed {
    logic signed [SAMP_W-1:0] i;
    logic signed [SAMP_W-1:0] q;
  } samp_t;

  typedef struct packed {
    logic signed [COEF_W-1:0] i;
    logic signed [COEF_W-1:0] q;
  } coef_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    ROUND = 2'd2
  } state_e;
endpackage

// File: rtl/firc_sym_mac_sym_fifo.sv
// Input sample FIFO. A push into a full FIFO is accepted only when a pop
// frees a slot on the same edge; otherwise the sample is dropped.
module sym_fifo
  import fir_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  logic  pop,
  input  samp_t din,
  output samp_t dout,
  output logic  full,
  output logic  empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  samp_t         mem_q [DEPTH];
  samp_t         mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  assign dout = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/firc_sym_mac.sv
// Complex symmetric FIR with one sequential complex MAC over folded tap pairs,
// double-banked coefficients, integer decimation and round/saturate output.
module firc_sym_mac
  import fir_pkg::*;
#(
  parameter int NTAPS      = 29,
  parameter int DECIM      = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int ACC_W      = 60,
  parameter int OUT_LSB    = 24
) (
  input  logic                              clk,
  input  logic                              Reset,
  input  logic                              PushIn,
  output logic                              StopIn,
  input  logic signed [SAMP_W-1:0]          SampI,
  input  logic signed [SAMP_W-1:0]          SampQ,
  input  logic                              PushCoef,
  input  logic [$clog2((NTAPS+1)/2)-1:0]    CoefAddr,
  input  logic signed [COEF_W-1:0]          CoefI,
  input  logic signed [COEF_W-1:0]          CoefQ,
  input  logic                              CoefSwap,
  output logic                              PushOut,
  output logic signed [OUT_W-1:0]           FI,
  output logic signed [OUT_W-1:0]           FQ,
  output logic                              Overflow,
  output logic                              Busy
);
  localparam int H    = (NTAPS + 1) / 2;
  localparam int AW   = $clog2(H);
  localparam int DW   = $clog2(NTAPS);
  localparam int PH_W = $clog2(DECIM + 1);
  localparam logic signed [ACC_W:0] RND_HALF =
    {{(ACC_W+1-OUT_LSB){1'b0}}, 1'b1, {(OUT_LSB-1){1'b0}}};

  function automatic logic signed [ACC_W:0] round_acc(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W:0] t;
    t = (ACC_W+1)'(a) + RND_HALF;
    return t >>> OUT_LSB;
  endfunction

  // Result is {overflow, value}; in range only when the bits above the
  // output sign bit are all copies of it.
  function automatic logic [OUT_W:0] sat_out(input logic signed [ACC_W:0] r);
    if (&r[ACC_W:OUT_W-1] || ~|r[ACC_W:OUT_W-1]) return {1'b0, r[OUT_W-1:0]};
    else if (r[ACC_W]) return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    else return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
  endfunction

  state_e                    state_q, state_d;
  logic [PH_W-1:0]           phase_q, phase_d;
  logic [AW-1:0]             tap_q, tap_d;
  logic signed [ACC_W-1:0]   acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  samp_t [NTAPS-1:0]         dl_q, dl_d;
  coef_t [1:0][H-1:0]        bank_q, bank_d;
  logic                      active_q, active_d, pend_q, pend_d;
  logic                      push_out_q, push_out_d, ovf_q, ovf_d;
  logic signed [OUT_W-1:0]   fi_q, fi_d, fq_q, fq_d;

  samp_t                     fifo_din, fifo_dout;
  logic                      fifo_pop, fifo_full, fifo_empty;

  logic [DW-1:0]             lo_idx, hi_idx;
  samp_t                     s_lo, s_hi;
  coef_t                     c_act;
  logic signed [FOLD_W-1:0]  a_re, a_im;
  logic signed [PROD_W-1:0]  p_re, p_im;
  logic [OUT_W:0]            o_re, o_im;

  assign fifo_din = '{i: SampI, q: SampQ};

  sym_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (Reset),
    .push  (PushIn),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Fold stage: pair s[tap] with its mirror; the centre tap stands alone.
  always_comb begin
    lo_idx = DW'(tap_q);
    hi_idx = DW'(NTAPS - 1) - lo_idx;
    s_lo   = dl_q[lo_idx];
    s_hi   = dl_q[hi_idx];
    c_act  = bank_q[active_q][tap_q];
    if (tap_q == AW'(H - 1)) begin
      a_re = FOLD_W'($signed(s_lo.i));
      a_im = FOLD_W'($signed(s_lo.q));
    end else begin
      a_re = FOLD_W'($signed(s_lo.i)) + FOLD_W'($signed(s_hi.i));
      a_im = FOLD_W'($signed(s_lo.q)) + FOLD_W'($signed(s_hi.q));
    end
    p_re = PROD_W'(a_re) * PROD_W'($signed(c_act.i)) - PROD_W'(a_im) * PROD_W'($signed(c_act.q));
    p_im = PROD_W'(a_re) * PROD_W'($signed(c_act.q)) + PROD_W'(a_im) * PROD_W'($signed(c_act.i));
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    tap_d      = tap_q;
    acc_re_d   = acc_re_q;
    acc_im_d   = acc_im_q;
    dl_d       = dl_q;
    bank_d     = bank_q;
    active_d   = active_q;
    pend_d     = pend_q | CoefSwap;
    push_out_d = 1'b0;
    fi_d       = fi_q;
    fq_d       = fq_q;
    ovf_d      = ovf_q;
    fifo_pop   = 1'b0;
    o_re       = '0;
    o_im       = '0;

    // Writes always target the bank that was shadow before this edge.
    if (PushCoef && int'(CoefAddr) < H) bank_d[~active_q][CoefAddr] = '{i: CoefI, q: CoefQ};

    case (state_q)
      IDLE: begin
        if (pend_d) begin
          active_d = ~active_q;
          pend_d   = 1'b0;
        end
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          dl_d     = {dl_q[NTAPS-2:0], fifo_dout};
          if (phase_q == PH_W'(DECIM - 1)) begin
            phase_d  = '0;
            acc_re_d = '0;
            acc_im_d = '0;
            tap_d    = '0;
            state_d  = MAC;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
      MAC: begin
        acc_re_d = acc_re_q + ACC_W'(p_re);
        acc_im_d = acc_im_q + ACC_W'(p_im);
        if (tap_q == AW'(H - 1)) state_d = ROUND;
        else tap_d = tap_q + 1'b1;
      end
      ROUND: begin
        o_re       = sat_out(round_acc(acc_re_q));
        o_im       = sat_out(round_acc(acc_im_q));
        fi_d       = o_re[OUT_W-1:0];
        fq_d       = o_im[OUT_W-1:0];
        ovf_d      = ovf_q | o_re[OUT_W] | o_im[OUT_W];
        push_out_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      tap_q      <= '0;
      acc_re_q   <= '0;
      acc_im_q   <= '0;
      dl_q       <= '0;
      bank_q     <= '0;
      active_q   <= 1'b0;
      pend_q     <= 1'b0;
      push_out_q <= 1'b0;
      fi_q       <= '0;
      fq_q       <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      tap_q      <= tap_d;
      acc_re_q   <= acc_re_d;
      acc_im_q   <= acc_im_d;
      dl_q       <= dl_d;
      bank_q     <= bank_d;
      active_q   <= active_d;
      pend_q     <= pend_d;
      push_out_q <= push_out_d;
      fi_q       <= fi_d;
      fq_q       <= fq_d;
      ovf_q      <= ovf_d;
    end
  end

  assign StopIn   = fifo_full;
  assign PushOut  = push_out_q;
  assign FI       = fi_q;
  assign FQ       = fq_q;
  assign Overflow = ovf_q;
  assign Busy     = (state_q != IDLE);
endmodule

// File: doc/firc_sym_mac.md
Name: firc_sym_mac

Overview:
Parametrised complex symmetric-FIR engine, next generation of the fixed 29-tap filter top. One sequential complex MAC folds tap pairs s[k]+s[N-1-k]. Adds an input FIFO, double-banked coefficients with glitch-free bank swap, integer decimation, and rounding/saturating output. Sits between the sample source (PushIn/StopIn) and the downstream consumer (PushOut).

Parameters:
NTAPS, 29, filter length; must be odd, >=3; H=(NTAPS+1)/2 folded taps
DECIM, 1, one output per DECIM accepted samples (1..16)
FIFO_DEPTH, 4, input FIFO entries (power of 2)
ACC_W, 60, accumulator width per rail; must be >= 53+clog2(H)
OUT_LSB, 24, accumulator bit mapped to output LSB

Ports:
clk  in  1  clock
Reset  in  1  synchronous, active-high reset
PushIn  in  1  sample valid
StopIn  out  1  FIFO full (combinational from count)
SampI, SampQ  in  24 each  signed 1.23 sample
PushCoef  in  1  coefficient write strobe
CoefAddr  in  clog2(H)  folded tap index, 0..H-1; H-1 is the centre tap
CoefI, CoefQ  in  27 each  signed 3.24 coefficient
CoefSwap  in  1  request swap of shadow/active banks
PushOut  out  1  output valid, one-cycle pulse
FI, FQ  out  32 each  signed result
Overflow  out  1  sticky: output saturation occurred
Busy  out  1  FSM not in IDLE

Behaviour:
- One clock: clk. Reset is synchronous and active-high: Reset sampled high at a posedge clears FIFO (empty), delay line, accumulators, both coef banks, active bank=0, swap-pending=0, decim phase=0, PushOut=0, FI=FQ=0, Overflow=0, FSM=IDLE. Reset mid-MAC aborts; no PushOut.
- FIFO: push accepted iff PushIn && (count<FIFO_DEPTH || pop same edge). Push while full without pop drops the sample. Simultaneous push+pop keeps count.
- FSM IDLE: if FIFO non-empty, pop; delay line shifts (s[0]<=head, s[i+1]<=s[i]); phase++. If phase was DECIM-1: phase<=0, acc<=0, tap<=0, go MAC. Else stay IDLE.
- MAC: H cycles, tap 0..H-1. For tap<H-1: a=s[tap]+s[NTAPS-1-tap] (25b). For tap=H-1: a=s[H-1] (not doubled). Complex product with active-bank coef c: accI+=aI*cI-aQ*cQ, accQ+=aI*cQ+aQ*cI, full-precision sign-extended to ACC_W. Products have 47 fractional bits. After tap H-1, go ROUND.
- ROUND: r=(acc+2^(OUT_LSB-1))>>>OUT_LSB. If r is outside the signed 32-bit range, saturate to 0x7FFFFFFF/0x80000000 and set Overflow. Register FI/FQ, PushOut=1 for one cycle, go IDLE. No pop in ROUND.
- Latency: PushOut is high in the cycle H+1 clocks after the pop edge that completed the decimation group (default: 16). FI/FQ hold until the next PushOut.
- No pops during MAC/ROUND. The delay line is frozen while computing.
- Coefficients: PushCoef writes the shadow bank (bank != active as sampled before the edge). CoefAddr>=H is ignored. CoefSwap sets pending. Pending with FSM in IDLE toggles the active bank at that edge and clears pending. The active bank never changes during MAC/ROUND. PushCoef and swap on the same edge: the write lands in the pre-edge shadow, which becomes active.
- No backpressure on PushOut.

Decomposition:
- Shared package fir_pkg: Samp/Coef struct typedefs (I,Q), sample/coef/output width constants, FSM state enum {IDLE, MAC, ROUND}.
- One sub-module: sym_fifo (parametrised depth, count, full/empty).
- Fold adder, complex MAC and round/saturate stay inline.

Test Plan:
- Impulse, defaults: coef[0]=(0x1000000,0), swap, push I=0x400000 then 28 zeros -> outputs #1 and #29 are FI=0x00400000, FQ=0. All other outputs 0. PushOut 16 cycles after each pop.
- Complex coef: coef[0]=(0,0x1000000), impulse I=0x400000 -> output #1 FI=0, FQ=0x00400000.
- Centre tap: only coef[14]=(0x1000000,0), impulse I=0x400000 -> output #15 only, FI=0x00400000 (not doubled).
- Bank swap mid-stream: load new shadow and pulse CoefSwap during MAC -> current output uses old bank; swap takes effect next IDLE, and the next output uses the new bank.
- Saturation, OUT_LSB=16: all coefs 0x3FFFFFF, samples 0x7FFFFF -> FI=0x7FFFFFFF, Overflow=1, remains 1 until Reset.
- Backpressure/decimation, DECIM=2: burst of 8 back-to-back samples -> StopIn high at count 4, extra pushes dropped, PushOut every second pop. Reset mid-MAC -> no PushOut, FIFO empty.
